// File: rtl/serial_adder_sequencer.sv
// Bit-serial sequencer driving a single pulse-clocked one-bit full adder.
// Issues one bit per ADD_LATENCY+1 cycles, rippling the carry through the adder.
module serial_adder_sequencer #(
    parameter int WIDTH       = 8,
    parameter int ADD_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    output logic             add_issue,
    input  logic             add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             protocol_err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;

    assign last_bit = (idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = ISSUE;
            ISSUE:   next_state = (ADD_LATENCY == 1) ? CAPTURE : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) next_state = CAPTURE;
            CAPTURE: next_state = last_bit ? DONE : ISSUE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands only need to be valid while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_a <= in_a;
            op_b <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            out_sum      <= '0;
            out_cout     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            // Adder outputs are only legal in the capture slot.
            if ((add_sum || add_cout) && state != CAPTURE) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx      <= '0;
                        carry    <= in_cin;
                        out_sum  <= '0;
                        out_cout <= 1'b0;
                    end
                end
                ISSUE: cnt <= CNT_W'(ADD_LATENCY - 1);
                WAIT:  cnt <= cnt - CNT_W'(1);
                CAPTURE: begin
                    out_sum[idx] <= add_sum;
                    carry        <= add_cout;
                    if (last_bit) begin
                        out_cout <= add_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulses decode straight from state so they drop as soon as reset asserts.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign add_issue = (state == ISSUE);
    assign add_a     = add_issue & op_a[idx];
    assign add_b     = add_issue & op_b[idx];
    assign add_cin   = add_issue & carry;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed bench for serial_adder_sequencer: one instance at ADD_LATENCY=3,
// one at ADD_LATENCY=1, each wired to a behavioural pipelined full adder.
module tb_serial_adder_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy, protocol_err;
    logic [7:0] in_a, in_b, out_sum;
    logic       add_a, add_b, add_cin, add_issue, add_sum, add_cout, inject;

    logic       in_valid_m, in_ready_m, in_cin_m, out_valid_m, out_ready_m, out_cout_m, busy_m, protocol_err_m;
    logic [7:0] in_a_m, in_b_m, out_sum_m;
    logic       add_a_m, add_b_m, add_cin_m, add_issue_m, add_sum_m, add_cout_m;

    serial_adder_sequencer #(.WIDTH(8), .ADD_LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_issue(add_issue),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .busy(busy), .protocol_err(protocol_err)
    );

    serial_adder_sequencer #(.WIDTH(8), .ADD_LATENCY(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .in_a(in_a_m), .in_b(in_b_m), .in_cin(in_cin_m),
        .add_a(add_a_m), .add_b(add_b_m), .add_cin(add_cin_m), .add_issue(add_issue_m),
        .add_sum(add_sum_m), .add_cout(add_cout_m),
        .out_valid(out_valid_m), .out_ready(out_ready_m), .out_sum(out_sum_m), .out_cout(out_cout_m),
        .busy(busy_m), .protocol_err(protocol_err_m)
    );

    // Behavioural adders: {cout,sum} valid ADD_LATENCY cycles after the issue cycle.
    logic [1:0] pipe3 [0:2];
    logic [1:0] pipe1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe3[0] <= 2'b00;
            pipe3[1] <= 2'b00;
            pipe3[2] <= 2'b00;
            pipe1    <= 2'b00;
        end else begin
            pipe3[0] <= add_issue ? {(add_a & add_b) | (add_a & add_cin) | (add_b & add_cin),
                                     add_a ^ add_b ^ add_cin} : 2'b00;
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
            pipe1    <= add_issue_m ? {(add_a_m & add_b_m) | (add_a_m & add_cin_m) | (add_b_m & add_cin_m),
                                       add_a_m ^ add_b_m ^ add_cin_m} : 2'b00;
        end
    end

    assign add_sum    = pipe3[2][0] | inject;
    assign add_cout   = pipe3[2][1];
    assign add_sum_m  = pipe1[0];
    assign add_cout_m = pipe1[1];

    int checks   = 0;
    int failures = 0;
    logic [7:0] a_mask, b_mask, c_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts from just after a negedge; returns at the negedge of the first out_valid cycle.
    task automatic run_op(input bit sel, input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] exp_sum, input logic exp_cout, input int exp_lat);
        int n = 0;
        int lat = 0;
        logic seen = 1'b0;
        a_mask = 8'h00; b_mask = 8'h00; c_mask = 8'h00;
        if (sel) begin in_a_m = a; in_b_m = b; in_cin_m = c; in_valid_m = 1'b1; end
        else     begin in_a   = a; in_b   = b; in_cin   = c; in_valid   = 1'b1; end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid_m = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if ((sel ? add_issue_m : add_issue) && n < 8) begin
                a_mask[n] = sel ? add_a_m   : add_a;
                b_mask[n] = sel ? add_b_m   : add_b;
                c_mask[n] = sel ? add_cin_m : add_cin;
                n++;
            end
            if (sel ? out_valid_m : out_valid) begin
                lat  = cyc;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_sum"},  32'(sel ? out_sum_m : out_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(sel ? out_cout_m : out_cout), 32'(exp_cout));
        chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
        chk({tag, "_issues"}, 32'(n), 32'd8);
    endtask

    task automatic accept(input bit sel, input string tag);
        if (sel) out_ready_m = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0; out_ready_m = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready_after"}, 32'(sel ? in_ready_m : in_ready), 32'd1);
        chk({tag, "_valid_dropped"}, 32'(sel ? out_valid_m : out_valid), 32'd0);
    endtask

    initial begin
        logic ok;
        logic busy_before;
        rst_n = 1'b0; inject = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_cin = 1'b0; out_ready = 1'b0;
        in_valid_m = 1'b0; in_a_m = 8'h00; in_b_m = 8'h00; in_cin_m = 1'b0; out_ready_m = 1'b0;
        #2;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum), 32'd0);
        chk("rst_out_cout",  32'(out_cout), 32'd0);
        chk("rst_pulses",    32'({add_a, add_b, add_cin, add_issue}), 32'd0);
        chk("rst_perr",      32'(protocol_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, "basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 33);
        chk("basic_cin_pulses", 32'(c_mask), 32'hE4);
        accept(1'b0, "basic");

        run_op(1'b0, "ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 33);
        chk("ripple_a_pulses",   32'(a_mask), 32'hFF);
        chk("ripple_b_pulses",   32'(b_mask), 32'h01);
        chk("ripple_cin_pulses", 32'(c_mask), 32'hFE);
        accept(1'b0, "ripple");

        run_op(1'b0, "sat", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 33);
        chk("sat_a_pulses",   32'(a_mask), 32'hFF);
        chk("sat_b_pulses",   32'(b_mask), 32'hFF);
        chk("sat_cin_pulses", 32'(c_mask), 32'hFF);
        chk("sat_perr_clean", 32'(protocol_err), 32'd0);

        // Backpressure with a competing request that must be ignored.
        ok = 1'b1;
        in_a = 8'h11; in_b = 8'h22; in_cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid && out_sum == 8'hFF && out_cout && !in_ready && busy)) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_stable", 32'(ok), 32'd1);
        accept(1'b0, "bp");

        // Abort during the bit-4 wait (bit 4 issues at cycle 17).
        in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        busy_before = busy;
        chk("abort_was_busy", 32'(busy_before), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  32'(in_ready), 32'd1);
        chk("abort_busy",      32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_sum",   32'(out_sum), 32'd0);
        chk("abort_pulses",    32'({add_a, add_b, add_cin, add_issue}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, "post_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 33);
        accept(1'b0, "post_abort");

        run_op(1'b1, "minlat", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 17);
        chk("minlat_perr_clean", 32'(protocol_err_m), 32'd0);
        accept(1'b1, "minlat");

        // Stray add_sum during the first wait of an operation.
        in_a = 8'h0F; in_b = 8'h01; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("perr_before_inject", 32'(protocol_err), 32'd0);
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        chk("perr_set", 32'(protocol_err), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("perr_op_done", 32'(ok), 32'd1);
        chk("perr_op_sum", 32'(out_sum), 32'h10);
        accept(1'b0, "perr");
        chk("perr_sticky", 32'(protocol_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("perr_cleared_by_reset", 32'(protocol_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
